// File: rtl/ov2640_config_sequencer.sv
// Walks a register/value ROM and issues SCCB writes to an OV2640, with power-up wait,
// inter-write gaps, extended settling after a sensor soft reset, and bounded NACK retries.
module ov2640_config_sequencer #(
    parameter int          ADDR_WIDTH     = 8,
    parameter int          DATA_WIDTH     = 16,
    parameter logic [7:0]  DEV_ID         = 8'h60,
    parameter logic [15:0] POWERUP_CYCLES = 16'd1000,
    parameter logic [15:0] GAP_CYCLES     = 16'd100,
    parameter logic [15:0] SRESET_CYCLES  = 16'd5000,
    parameter int          MAX_RETRY      = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic                  sccb_req,
    input  logic                  sccb_ready,
    output logic [7:0]            sccb_dev,
    output logic [7:0]            sccb_reg,
    output logic [7:0]            sccb_val,
    input  logic                  sccb_done,
    input  logic                  sccb_nack,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH-1:0] write_count
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        POWERUP  = 3'd1,
        FETCH    = 3'd2,
        ISSUE    = 3'd3,
        WAIT_ACK = 3'd4,
        GAP      = 3'd5,
        FINISH   = 3'd6
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = '1;
    localparam logic [7:0]            MAX_RETRY_W = 8'(MAX_RETRY);
    localparam logic [16:0]           SRESET_SUM  = {1'b0, GAP_CYCLES} + {1'b0, SRESET_CYCLES};
    localparam logic [15:0]           SRESET_GAP  = SRESET_SUM[16] ? 16'hFFFF : SRESET_SUM[15:0];

    state_t                  state, state_next;
    logic [15:0]             cnt, cnt_next;
    logic [ADDR_WIDTH-1:0]   addr_next, wc_next;
    logic [7:0]              dev_next, reg_next, val_next;
    logic [7:0]              retries, retries_next;
    logic                    bank, bank_next;
    logic                    retry_pend, retry_pend_next;
    logic                    done_next, error_next;
    logic                    is_sreset;

    assign sccb_req  = (state == ISSUE);
    assign busy      = (state == POWERUP) || (state == FETCH) || (state == ISSUE) ||
                       (state == WAIT_ACK) || (state == GAP);
    assign is_sreset = bank && (sccb_reg == 8'h12) && sccb_val[7];

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            rom_addr    <= '0;
            write_count <= '0;
            sccb_dev    <= '0;
            sccb_reg    <= '0;
            sccb_val    <= '0;
            retries     <= '0;
            bank        <= 1'b0;
            retry_pend  <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            rom_addr    <= addr_next;
            write_count <= wc_next;
            sccb_dev    <= dev_next;
            sccb_reg    <= reg_next;
            sccb_val    <= val_next;
            retries     <= retries_next;
            bank        <= bank_next;
            retry_pend  <= retry_pend_next;
            done        <= done_next;
            error       <= error_next;
        end
    end

    always_comb begin
        state_next      = state;
        cnt_next        = cnt;
        addr_next       = rom_addr;
        wc_next         = write_count;
        dev_next        = sccb_dev;
        reg_next        = sccb_reg;
        val_next        = sccb_val;
        retries_next    = retries;
        bank_next       = bank;
        retry_pend_next = retry_pend;
        done_next       = done;
        error_next      = error;

        unique case (state)
            IDLE, FINISH: begin
                if (start) begin
                    addr_next  = '0;
                    wc_next    = '0;
                    done_next  = 1'b0;
                    error_next = 1'b0;
                    bank_next  = 1'b0;
                    cnt_next   = POWERUP_CYCLES;
                    state_next = POWERUP;
                end
            end
            POWERUP, GAP: begin
                if (cnt == 16'd0) begin
                    // a retry re-issues the latched fields instead of refetching
                    state_next = (state == GAP && retry_pend) ? ISSUE : FETCH;
                end else begin
                    cnt_next = cnt - 16'd1;
                end
            end
            FETCH: begin
                if (rom_data[15:0] == 16'hFFFF) begin
                    done_next  = 1'b1;
                    error_next = 1'b0;
                    state_next = FINISH;
                end else begin
                    dev_next        = DEV_ID;
                    reg_next        = rom_data[15:8];
                    val_next        = rom_data[7:0];
                    retries_next    = '0;
                    retry_pend_next = 1'b0;
                    state_next      = ISSUE;
                end
            end
            ISSUE: begin
                if (sccb_ready) state_next = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (sccb_done) begin
                    if (!sccb_nack) begin
                        wc_next         = write_count + 1'b1;
                        retry_pend_next = 1'b0;
                        if (sccb_reg == 8'hFF) bank_next = sccb_val[0];
                        cnt_next = is_sreset ? SRESET_GAP : GAP_CYCLES;
                        if (rom_addr == LAST_ADDR) begin
                            error_next = 1'b1;
                            state_next = FINISH;
                        end else begin
                            addr_next  = rom_addr + 1'b1;
                            state_next = GAP;
                        end
                    end else if (retries < MAX_RETRY_W) begin
                        retries_next    = retries + 8'd1;
                        retry_pend_next = 1'b1;
                        cnt_next        = GAP_CYCLES;
                        state_next      = GAP;
                    end else begin
                        error_next = 1'b1;
                        state_next = FINISH;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ov2640_config_sequencer.sv
// Directed bench for ov2640_config_sequencer: table ROM, behavioural SCCB master with
// fixed two-cycle completion latency and per-register NACK injection.
module tb_ov2640_config_sequencer;

    localparam int          AW = 8;
    localparam logic [15:0] PU = 16'd4;
    localparam logic [15:0] GP = 16'd2;
    localparam logic [15:0] SR = 16'd20;

    logic          clk = 1'b0;
    logic          reset, start, sccb_ready, sccb_done, sccb_nack;
    logic [AW-1:0] rom_addr, write_count;
    logic [15:0]   rom_data;
    logic          sccb_req, busy, done, error;
    logic [7:0]    sccb_dev, sccb_reg, sccb_val;

    logic [15:0] rom [256];
    assign rom_data = rom[rom_addr];

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    int         acc_cnt = 0;
    logic [7:0] rec_dev [512];
    logic [7:0] rec_reg [512];
    logic [7:0] rec_val [512];
    int         rec_cyc [512];
    logic       nack_en = 1'b0;
    logic [7:0] nack_reg = 8'h00;

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    ov2640_config_sequencer #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(16), .DEV_ID(8'h60),
        .POWERUP_CYCLES(PU), .GAP_CYCLES(GP), .SRESET_CYCLES(SR), .MAX_RETRY(2)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .sccb_req(sccb_req), .sccb_ready(sccb_ready),
        .sccb_dev(sccb_dev), .sccb_reg(sccb_reg), .sccb_val(sccb_val),
        .sccb_done(sccb_done), .sccb_nack(sccb_nack),
        .busy(busy), .done(done), .error(error), .write_count(write_count)
    );

    // SCCB master model: acceptance seen at the next edge, done pulse two cycles later
    initial begin
        int   pending;
        logic nk;
        pending   = 0;
        nk        = 1'b0;
        sccb_done = 1'b0;
        sccb_nack = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            sccb_done = 1'b0;
            sccb_nack = 1'b0;
            if (pending > 0) begin
                pending = pending - 1;
                if (pending == 0) begin
                    sccb_done = 1'b1;
                    sccb_nack = nk;
                end
            end else if (sccb_req && sccb_ready && !reset) begin
                if (acc_cnt < 512) begin
                    rec_dev[acc_cnt] = sccb_dev;
                    rec_reg[acc_cnt] = sccb_reg;
                    rec_val[acc_cnt] = sccb_val;
                    rec_cyc[acc_cnt] = cycle;
                end
                nk      = nack_en && (sccb_reg == nack_reg);
                acc_cnt = acc_cnt + 1;
                pending = 2;
            end
        end
    end

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_idle(input int limit, input string name);
        int n;
        n = 0;
        while (busy && n < limit) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy) begin
            errors++;
            $display("FAIL %s timeout: busy still 1 after %0d cycles", name, limit);
        end
    endtask

    task automatic test_reset();
        clear_rom();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done, error, sccb_req} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_status: busy/done/error/req got %b expected 0000", {busy, done, error, sccb_req});
        end
        checks++;
        if (rom_addr !== 8'd0 || write_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_counts: rom_addr %0d write_count %0d expected 0 0", rom_addr, write_count);
        end
        checks++;
        if ({sccb_dev, sccb_reg, sccb_val} !== 24'h0) begin
            errors++;
            $display("FAIL reset_fields: got %h expected 000000", {sccb_dev, sccb_reg, sccb_val});
        end
    endtask

    task automatic test_basic();
        int base;
        clear_rom();
        rom[0] = 16'hFF00;
        rom[1] = 16'h2CFF;
        base = acc_cnt;
        pulse_start();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_busy: got %b expected 1", busy);
        end
        wait_idle(200, "basic");
        checks++;
        if (acc_cnt - base !== 2) begin
            errors++;
            $display("FAIL basic_req_count: got %0d expected 2", acc_cnt - base);
        end
        checks++;
        if ({rec_dev[base], rec_reg[base], rec_val[base]} !== 24'h60FF00) begin
            errors++;
            $display("FAIL basic_req0: got %h expected 60FF00", {rec_dev[base], rec_reg[base], rec_val[base]});
        end
        checks++;
        if ({rec_dev[base+1], rec_reg[base+1], rec_val[base+1]} !== 24'h602CFF) begin
            errors++;
            $display("FAIL basic_req1: got %h expected 602CFF", {rec_dev[base+1], rec_reg[base+1], rec_val[base+1]});
        end
        checks++;
        if (done !== 1'b1 || error !== 1'b0 || write_count !== 8'd2 || rom_addr !== 8'd2) begin
            errors++;
            $display("FAIL basic_end: done %b error %b wc %0d addr %0d expected 1 0 2 2", done, error, write_count, rom_addr);
        end
    endtask

    task automatic test_back_to_back();
        int base;
        base = acc_cnt;
        pulse_start();
        checks++;
        if (done !== 1'b0 || busy !== 1'b1 || write_count !== 8'd0) begin
            errors++;
            $display("FAIL restart_clear: done %b busy %b wc %0d expected 0 1 0", done, busy, write_count);
        end
        wait_idle(200, "restart");
        checks++;
        if (done !== 1'b1 || write_count !== 8'd2 || acc_cnt - base !== 2) begin
            errors++;
            $display("FAIL restart_end: done %b wc %0d reqs %0d expected 1 2 2", done, write_count, acc_cnt - base);
        end
    endtask

    task automatic test_ready_stall();
        int         base, n;
        logic [23:0] snap;
        clear_rom();
        rom[0] = 16'h1234;
        base = acc_cnt;
        sccb_ready = 1'b0;
        pulse_start();
        n = 0;
        while (!sccb_req && n < 100) begin
            @(negedge clk);
            n++;
        end
        snap = {sccb_dev, sccb_reg, sccb_val};
        checks++;
        if (snap !== 24'h601234) begin
            errors++;
            $display("FAIL stall_fields: got %h expected 601234", snap);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (sccb_req !== 1'b1 || {sccb_dev, sccb_reg, sccb_val} !== snap) begin
                errors++;
                $display("FAIL stall_hold: cycle %0d req %b fields %h expected 1 %h", i, sccb_req, {sccb_dev, sccb_reg, sccb_val}, snap);
            end
        end
        sccb_ready = 1'b1;
        wait_idle(200, "stall");
        checks++;
        if (acc_cnt - base !== 1 || write_count !== 8'd1 || done !== 1'b1) begin
            errors++;
            $display("FAIL stall_accept: reqs %0d wc %0d done %b expected 1 1 1", acc_cnt - base, write_count, done);
        end
    endtask

    task automatic test_sreset_gap();
        int base;
        clear_rom();
        rom[0] = 16'hFF00;
        rom[1] = 16'h1280;
        rom[2] = 16'hFF01;
        rom[3] = 16'h1280;
        rom[4] = 16'hFF00;
        base = acc_cnt;
        pulse_start();
        wait_idle(500, "sreset");
        checks++;
        if (acc_cnt - base !== 5 || done !== 1'b1) begin
            errors++;
            $display("FAIL sreset_reqs: reqs %0d done %b expected 5 1", acc_cnt - base, done);
        end
        // request-to-request spacing: 2 ack latency + gap count + 1 gap exit + fetch + issue
        checks++;
        if (rec_cyc[base+2] - rec_cyc[base+1] !== int'(GP) + 5) begin
            errors++;
            $display("FAIL gap_bank0: got %0d expected %0d", rec_cyc[base+2] - rec_cyc[base+1], int'(GP) + 5);
        end
        checks++;
        if (rec_cyc[base+4] - rec_cyc[base+3] !== int'(GP) + int'(SR) + 5) begin
            errors++;
            $display("FAIL gap_sreset: got %0d expected %0d", rec_cyc[base+4] - rec_cyc[base+3], int'(GP) + int'(SR) + 5);
        end
    endtask

    task automatic test_nack_retry();
        int base;
        clear_rom();
        rom[0] = 16'h1111;
        rom[1] = 16'h2222;
        base = acc_cnt;
        nack_en  = 1'b1;
        nack_reg = 8'h22;
        pulse_start();
        wait_idle(300, "nack");
        nack_en = 1'b0;
        checks++;
        if (acc_cnt - base !== 4) begin
            errors++;
            $display("FAIL nack_req_count: got %0d expected 4", acc_cnt - base);
        end
        for (int i = 1; i <= 3; i++) begin
            checks++;
            if ({rec_dev[base+i], rec_reg[base+i], rec_val[base+i]} !== 24'h602222) begin
                errors++;
                $display("FAIL nack_retry_fields: attempt %0d got %h expected 602222", i, {rec_dev[base+i], rec_reg[base+i], rec_val[base+i]});
            end
        end
        checks++;
        if (error !== 1'b1 || done !== 1'b0 || rom_addr !== 8'd1 || write_count !== 8'd1) begin
            errors++;
            $display("FAIL nack_end: error %b done %b addr %0d wc %0d expected 1 0 1 1", error, done, rom_addr, write_count);
        end
    endtask

    task automatic test_wrap();
        int         base;
        logic [7:0] idx;
        for (int i = 0; i < 256; i++) begin
            idx    = 8'(i);
            rom[i] = {8'h10, idx};
        end
        base = acc_cnt;
        pulse_start();
        repeat (100) @(negedge clk);
        pulse_start();
        wait_idle(6000, "wrap");
        checks++;
        if (acc_cnt - base !== 256) begin
            errors++;
            $display("FAIL wrap_req_count: got %0d expected 256", acc_cnt - base);
        end
        checks++;
        if (error !== 1'b1 || done !== 1'b0 || rom_addr !== 8'd255) begin
            errors++;
            $display("FAIL wrap_end: error %b done %b addr %0d expected 1 0 255", error, done, rom_addr);
        end
        checks++;
        if (rec_val[base+255] !== 8'hFF) begin
            errors++;
            $display("FAIL wrap_last_val: got %h expected ff", rec_val[base+255]);
        end
    endtask

    task automatic test_reset_mid_ack();
        int base, n;
        clear_rom();
        rom[0] = 16'h3344;
        rom[1] = 16'h5566;
        base = acc_cnt;
        pulse_start();
        n = 0;
        while (acc_cnt == base && n < 100) begin
            @(negedge clk);
            n++;
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (sccb_req !== 1'b0 || busy !== 1'b0 || rom_addr !== 8'd0) begin
            errors++;
            $display("FAIL midreset_drop: req %b busy %b addr %0d expected 0 0 0", sccb_req, busy, rom_addr);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || write_count !== 8'd0 || done !== 1'b0) begin
            errors++;
            $display("FAIL midreset_stray_done: busy %b wc %0d done %b expected 0 0 0", busy, write_count, done);
        end
        base = acc_cnt;
        pulse_start();
        wait_idle(200, "midreset");
        checks++;
        if (acc_cnt - base !== 2 || rec_reg[base] !== 8'h33 || write_count !== 8'd2 || done !== 1'b1) begin
            errors++;
            $display("FAIL midreset_restart: reqs %0d reg0 %h wc %0d done %b expected 2 33 2 1", acc_cnt - base, rec_reg[base], write_count, done);
        end
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        sccb_ready = 1'b1;
        test_reset();
        test_basic();
        test_back_to_back();
        test_ready_stall();
        test_sreset_gap();
        test_nack_retry();
        test_wrap();
        test_reset_mid_ack();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
